// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered memory loads onto the register-file
// write port, with a 2-entry load FIFO, pending-destination mask and starvation stall.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alu_valid_i,
  input  logic [2:0] alu_addr_i,
  input  logic [7:0] alu_data_i,
  input  logic       alu_cb_valid_i,
  input  logic       alu_cb_i,
  input  logic       mem_valid_i,
  input  logic [2:0] mem_addr_i,
  input  logic [7:0] mem_data_i,
  output logic       mem_ready_o,
  output logic       write_o,
  output logic [2:0] write_addr_o,
  output logic [7:0] write_data_o,
  output logic       write_CB_o,
  output logic       cb_data_o,
  output logic [7:0] busy_o,
  output logic       stall_o,
  output logic       err_o
);

  localparam logic [2:0] StarveLim = 3'(STARVE_LIMIT);

  logic [2:0] fifo_addr_q [2];
  logic [7:0] fifo_data_q [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q;
  logic [2:0] age_q, age_d;
  logic       err_q;

  logic       write_q, write_d;
  logic [2:0] write_addr_q, write_addr_d;
  logic [7:0] write_data_q, write_data_d;
  logic       write_cb_q, cb_data_q;

  logic       non_empty;
  logic       push, pop, sel_alu;

  assign non_empty   = (count_q != 2'd0);
  // Ready looks only at the registered count; a same-cycle pop does not free a slot.
  assign mem_ready_o = !rst_i && (count_q < 2'd2);
  assign push        = mem_valid_i && mem_ready_o;
  assign stall_o     = non_empty && (age_q >= StarveLim);

  // Stall forces the head out and drops any ALU result; otherwise ALU has priority.
  assign pop     = non_empty && (stall_o || !alu_valid_i);
  assign sel_alu = alu_valid_i && !stall_o;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_comb begin
    age_d = age_q;
    if (!non_empty || pop) begin
      age_d = 3'd0;
    end else if (age_q != 3'd7) begin
      age_d = age_q + 3'd1;
    end
  end

  always_comb begin
    write_d      = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (sel_alu) begin
      write_d      = 1'b1;
      write_addr_d = alu_addr_i;
      write_data_d = alu_data_i;
    end else if (pop) begin
      write_d      = 1'b1;
      write_addr_d = fifo_addr_q[rd_ptr_q];
      write_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_addr_q[0] <= 3'd0;
      fifo_addr_q[1] <= 3'd0;
      fifo_data_q[0] <= 8'd0;
      fifo_data_q[1] <= 8'd0;
      count_q        <= 2'd0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      age_q          <= 3'd0;
      err_q          <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= mem_addr_i;
        fifo_data_q[wr_ptr_q] <= mem_data_i;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      age_q   <= age_d;
      if (alu_valid_i && stall_o) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q      <= 1'b0;
      write_addr_q <= 3'd0;
      write_data_q <= 8'd0;
      write_cb_q   <= 1'b0;
      cb_data_q    <= 1'b0;
    end else begin
      write_q      <= write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      write_cb_q   <= alu_cb_valid_i;
      if (alu_cb_valid_i) begin
        cb_data_q <= alu_cb_i;
      end
    end
  end

  // Pending-destination mask covers only entries still held in the FIFO.
  always_comb begin
    busy_o = 8'd0;
    if (count_q != 2'd0) begin
      busy_o[fifo_addr_q[rd_ptr_q]] = 1'b1;
    end
    if (count_q == 2'd2) begin
      busy_o[fifo_addr_q[~rd_ptr_q]] = 1'b1;
    end
  end

  assign write_o      = write_q;
  assign write_addr_o = write_addr_q;
  assign write_data_o = write_data_q;
  assign write_CB_o   = write_cb_q;
  assign cb_data_o    = cb_data_q;
  assign err_o        = err_q;

endmodule
